// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, reads the instruction ROM combinationally,
// arbitrates all PC redirects and loads the IF/ID register consumed by decode.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] ILLOP_PC = 32'h8000_0004,
  parameter logic [31:0] XADR_PC  = 32'h8000_0008
) (
  input  logic        clk,
  input  logic        reset_b,
  input  logic        bubble,
  input  logic        PCSrcJ,
  input  logic        PCSrcJR,
  input  logic [31:0] jump_address,
  input  logic [31:0] jr_address,
  input  logic        exception,
  input  logic        EX_BranchTaken,
  input  logic [31:0] EX_BranchAddress,
  input  logic        IRQ,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        flush_ID,
  output logic [31:0] PC,
  output logic [64:0] IF_ID
);

  logic [31:0] r_pc;
  logic [64:0] r_if_id;
  logic        r_irq_pending;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_pc_next;
  logic [64:0] w_if_id_next;
  logic        w_irq_take;
  logic        w_irq_pending_next;

  // Bit 31 is the supervisor bit: incrementing never sets it and bit-30 carry is dropped.
  assign w_pc_plus4 = {r_pc[31], r_pc[30:0] + 31'd4};

  // Redirect arbitration, first match wins; the EX branch is older than anything in ID.
  always_comb begin
    w_pc_next    = r_pc;
    w_if_id_next = r_if_id;
    w_irq_take   = 1'b0;
    if (EX_BranchTaken) begin
      w_pc_next    = EX_BranchAddress;
      w_if_id_next = 65'd0;
    end else if (bubble) begin
      w_pc_next    = r_pc;
      w_if_id_next = r_if_id;
    end else if (exception) begin
      w_pc_next    = ILLOP_PC;
      w_if_id_next = 65'd0;
    end else if (PCSrcJR) begin
      w_pc_next    = jr_address;
      w_if_id_next = 65'd0;
    end else if (PCSrcJ) begin
      w_pc_next    = jump_address;
      w_if_id_next = 65'd0;
    end else if (r_irq_pending && !r_pc[31]) begin
      w_irq_take   = 1'b1;
      w_pc_next    = XADR_PC;
      w_if_id_next = {1'b1, 32'h0000_0000, w_pc_plus4};
    end else begin
      w_pc_next    = w_pc_plus4;
      w_if_id_next = {1'b0, imem_rdata, w_pc_plus4};
    end
  end

  // Interrupts are only latched from user space and wait until the first free edge.
  always_comb begin
    w_irq_pending_next = r_irq_pending;
    if (w_irq_take) begin
      w_irq_pending_next = 1'b0;
    end else if (IRQ && !r_pc[31] && !r_irq_pending) begin
      w_irq_pending_next = 1'b1;
    end else begin
      w_irq_pending_next = r_irq_pending;
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_pc          <= RESET_PC;
      r_if_id       <= 65'd0;
      r_irq_pending <= 1'b0;
    end else begin
      r_pc          <= w_pc_next;
      r_if_id       <= w_if_id_next;
      r_irq_pending <= w_irq_pending_next;
    end
  end

  assign PC        = r_pc;
  assign imem_addr = r_pc;
  assign IF_ID     = r_if_id;
  assign flush_ID  = EX_BranchTaken;

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: each step pushes the expected PC/IF_ID when the
// stimulus is driven and pops it after the clock edge that should produce it.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset_b;
  logic        bubble, PCSrcJ, PCSrcJR, exception, EX_BranchTaken, IRQ;
  logic [31:0] jump_address, jr_address, EX_BranchAddress;
  logic [31:0] imem_addr, imem_rdata, PC;
  logic        flush_ID;
  logic [64:0] IF_ID;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [64:0] if_id;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  // Instruction ROM; only the reset vector holds a fixed instruction.
  function automatic logic [31:0] rom(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h2008_0005;
    else return {a[15:0], ~a[15:0]};
  endfunction

  assign imem_rdata = rom(imem_addr);

  if_stage dut (
    .clk(clk), .reset_b(reset_b), .bubble(bubble), .PCSrcJ(PCSrcJ), .PCSrcJR(PCSrcJR),
    .jump_address(jump_address), .jr_address(jr_address), .exception(exception),
    .EX_BranchTaken(EX_BranchTaken), .EX_BranchAddress(EX_BranchAddress), .IRQ(IRQ),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .flush_ID(flush_ID), .PC(PC), .IF_ID(IF_ID)
  );

  task automatic idle();
    bubble = 1'b0; PCSrcJ = 1'b0; PCSrcJR = 1'b0; exception = 1'b0;
    EX_BranchTaken = 1'b0; IRQ = 1'b0;
    jump_address = 32'h0; jr_address = 32'h0; EX_BranchAddress = 32'h0;
  endtask

  task automatic push(input string name, input logic [31:0] pc, input logic [64:0] if_id);
    exp_t x;
    x.name = name; x.pc = pc; x.if_id = if_id;
    sb.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    reset_b = 1'b0;
    #12;
    total++;
    if (PC !== 32'h8000_0000 || imem_addr !== 32'h8000_0000) begin
      bad++; $display("FAIL reset_pc: PC=%h imem_addr=%h expected 80000000", PC, imem_addr);
    end
    total++;
    if (IF_ID !== 65'd0) begin
      bad++; $display("FAIL reset_if_id: IF_ID=%h expected 0", IF_ID);
    end
    total++;
    if (flush_ID !== 1'b0) begin
      bad++; $display("FAIL reset_flush: flush_ID=%b expected 0", flush_ID);
    end
    reset_b = 1'b1;
  endtask

  task automatic test_seq();
    exp_t e;
    logic [31:0] p;
    for (int s = 0; s < 4; s++) begin
      idle();
      p = 32'h8000_0000 + 32'(4 * s);
      push("seq", p + 32'h4, {1'b0, rom(p), p + 32'h4});
      tick();
      e = sb.pop_front();
      total++;
      if (PC !== e.pc || imem_addr !== e.pc) begin
        bad++; $display("FAIL %s[%0d]: PC=%h imem_addr=%h expected %h", e.name, s, PC, imem_addr, e.pc);
      end
      total++;
      if (IF_ID !== e.if_id) begin
        bad++; $display("FAIL %s[%0d]: IF_ID=%h expected %h", e.name, s, IF_ID, e.if_id);
      end
    end
  endtask

  task automatic test_stall();
    exp_t e;
    for (int s = 0; s < 3; s++) begin
      idle();
      case (s)
        0, 1: begin
          bubble = 1'b1;
          push("stall", 32'h8000_0010, {1'b0, rom(32'h8000_000C), 32'h8000_0010});
        end
        default: push("stall_resume", 32'h8000_0014, {1'b0, rom(32'h8000_0010), 32'h8000_0014});
      endcase
      tick();
      e = sb.pop_front();
      total++;
      if (PC !== e.pc || imem_addr !== e.pc) begin
        bad++; $display("FAIL %s[%0d]: PC=%h imem_addr=%h expected %h", e.name, s, PC, imem_addr, e.pc);
      end
      total++;
      if (IF_ID !== e.if_id) begin
        bad++; $display("FAIL %s[%0d]: IF_ID=%h expected %h", e.name, s, IF_ID, e.if_id);
      end
    end
  endtask

  task automatic test_jump();
    exp_t e;
    for (int s = 0; s < 4; s++) begin
      idle();
      case (s)
        0: begin
          PCSrcJ = 1'b1; jump_address = 32'h8000_0100;
          push("jump", 32'h8000_0100, 65'd0);
        end
        1: begin
          PCSrcJ = 1'b1; jump_address = 32'h8000_0200; bubble = 1'b1;
          push("jump_stalled", 32'h8000_0100, 65'd0);
        end
        2: push("jump_resume", 32'h8000_0104, {1'b0, rom(32'h8000_0100), 32'h8000_0104});
        default: begin
          PCSrcJ = 1'b1; jump_address = 32'h8000_0600;
          PCSrcJR = 1'b1; jr_address = 32'h8000_0700;
          push("j_and_jr", 32'h8000_0700, 65'd0);
        end
      endcase
      tick();
      e = sb.pop_front();
      total++;
      if (PC !== e.pc || imem_addr !== e.pc) begin
        bad++; $display("FAIL %s: PC=%h imem_addr=%h expected %h", e.name, PC, imem_addr, e.pc);
      end
      total++;
      if (IF_ID !== e.if_id) begin
        bad++; $display("FAIL %s: IF_ID=%h expected %h", e.name, IF_ID, e.if_id);
      end
    end
  endtask

  task automatic test_branch_exception();
    exp_t e;
    logic exp_flush;
    for (int s = 0; s < 5; s++) begin
      idle();
      exp_flush = 1'b0;
      case (s)
        0: begin
          EX_BranchTaken = 1'b1; EX_BranchAddress = 32'h8000_0040;
          bubble = 1'b1; PCSrcJ = 1'b1; jump_address = 32'h8000_0300;
          exp_flush = 1'b1;
          push("branch_over_stall", 32'h8000_0040, 65'd0);
        end
        1: push("after_branch", 32'h8000_0044, {1'b0, rom(32'h8000_0040), 32'h8000_0044});
        2: begin
          exception = 1'b1;
          push("exception", 32'h8000_0004, 65'd0);
        end
        3: begin
          exception = 1'b1; EX_BranchTaken = 1'b1; EX_BranchAddress = 32'h8000_0080;
          exp_flush = 1'b1;
          push("exc_vs_branch", 32'h8000_0080, 65'd0);
        end
        default: begin
          exception = 1'b1; PCSrcJR = 1'b1; jr_address = 32'h8000_0900;
          push("exc_vs_jr", 32'h8000_0004, 65'd0);
        end
      endcase
      #1;
      total++;
      if (flush_ID !== exp_flush) begin
        bad++; $display("FAIL flush_ID[%0d]: got %b expected %b", s, flush_ID, exp_flush);
      end
      tick();
      e = sb.pop_front();
      total++;
      if (PC !== e.pc || imem_addr !== e.pc) begin
        bad++; $display("FAIL %s: PC=%h imem_addr=%h expected %h", e.name, PC, imem_addr, e.pc);
      end
      total++;
      if (IF_ID !== e.if_id) begin
        bad++; $display("FAIL %s: IF_ID=%h expected %h", e.name, IF_ID, e.if_id);
      end
    end
  endtask

  task automatic test_pc_plus4_boundary();
    exp_t e;
    for (int s = 0; s < 4; s++) begin
      idle();
      case (s)
        0: begin
          PCSrcJ = 1'b1; jump_address = 32'h7FFF_FFFC;
          push("bnd_jump_user", 32'h7FFF_FFFC, 65'd0);
        end
        1: push("bnd_no_sup_set", 32'h0000_0000, {1'b0, rom(32'h7FFF_FFFC), 32'h0000_0000});
        2: begin
          PCSrcJ = 1'b1; jump_address = 32'hFFFF_FFFC;
          push("bnd_jump_kern", 32'hFFFF_FFFC, 65'd0);
        end
        default: push("bnd_keep_sup", 32'h8000_0000, {1'b0, rom(32'hFFFF_FFFC), 32'h8000_0000});
      endcase
      tick();
      e = sb.pop_front();
      total++;
      if (PC !== e.pc || imem_addr !== e.pc) begin
        bad++; $display("FAIL %s: PC=%h imem_addr=%h expected %h", e.name, PC, imem_addr, e.pc);
      end
      total++;
      if (IF_ID !== e.if_id) begin
        bad++; $display("FAIL %s: IF_ID=%h expected %h", e.name, IF_ID, e.if_id);
      end
    end
  endtask

  task automatic test_irq();
    exp_t e;
    for (int s = 0; s < 12; s++) begin
      idle();
      case (s)
        0: begin
          PCSrcJ = 1'b1; jump_address = 32'h0000_0200;
          push("irq_to_user", 32'h0000_0200, 65'd0);
        end
        1: begin
          IRQ = 1'b1; bubble = 1'b1;
          push("irq_latch_in_stall", 32'h0000_0200, 65'd0);
        end
        2: push("irq_accept", 32'h8000_0008, {1'b1, 32'h0, 32'h0000_0204});
        3: begin IRQ = 1'b1; push("irq_held_k0", 32'h8000_000C, {1'b0, rom(32'h8000_0008), 32'h8000_000C}); end
        4: begin IRQ = 1'b1; push("irq_held_k1", 32'h8000_0010, {1'b0, rom(32'h8000_000C), 32'h8000_0010}); end
        5: begin IRQ = 1'b1; push("irq_held_k2", 32'h8000_0014, {1'b0, rom(32'h8000_0010), 32'h8000_0014}); end
        6: begin
          PCSrcJ = 1'b1; jump_address = 32'h0000_0300;
          push("irq_to_user2", 32'h0000_0300, 65'd0);
        end
        7: begin
          IRQ = 1'b1; PCSrcJ = 1'b1; jump_address = 32'h8000_0500;
          push("irq_latch_jump_kern", 32'h8000_0500, 65'd0);
        end
        8: push("irq_wait_in_kern", 32'h8000_0504, {1'b0, rom(32'h8000_0500), 32'h8000_0504});
        9: begin
          PCSrcJ = 1'b1; jump_address = 32'h0000_0400;
          push("irq_preempted_by_j", 32'h0000_0400, 65'd0);
        end
        10: push("irq_late_accept", 32'h8000_0008, {1'b1, 32'h0, 32'h0000_0404});
        default: push("irq_no_second", 32'h8000_000C, {1'b0, rom(32'h8000_0008), 32'h8000_000C});
      endcase
      tick();
      e = sb.pop_front();
      total++;
      if (PC !== e.pc || imem_addr !== e.pc) begin
        bad++; $display("FAIL %s: PC=%h imem_addr=%h expected %h", e.name, PC, imem_addr, e.pc);
      end
      total++;
      if (IF_ID !== e.if_id) begin
        bad++; $display("FAIL %s: IF_ID=%h expected %h", e.name, IF_ID, e.if_id);
      end
    end
  endtask

  task automatic test_mid_reset();
    exp_t e;
    for (int s = 0; s < 4; s++) begin
      idle();
      case (s)
        0: begin
          PCSrcJ = 1'b1; jump_address = 32'h0000_0600;
          push("mr_to_user", 32'h0000_0600, 65'd0);
        end
        1: begin
          IRQ = 1'b1; bubble = 1'b1;
          push("mr_latch_irq", 32'h0000_0600, 65'd0);
        end
        2: begin
          PCSrcJ = 1'b1; jump_address = 32'h0000_0700;
          push("mr_after_reset_j", 32'h0000_0700, 65'd0);
        end
        default: push("mr_irq_discarded", 32'h0000_0704, {1'b0, rom(32'h0000_0700), 32'h0000_0704});
      endcase
      if (s == 2) begin
        #2 reset_b = 1'b0;
        #1;
        total++;
        if (PC !== 32'h8000_0000) begin
          bad++; $display("FAIL async_reset_pc: PC=%h expected 80000000", PC);
        end
        total++;
        if (IF_ID !== 65'd0) begin
          bad++; $display("FAIL async_reset_if_id: IF_ID=%h expected 0", IF_ID);
        end
        #1 reset_b = 1'b1;
      end
      tick();
      e = sb.pop_front();
      total++;
      if (PC !== e.pc || imem_addr !== e.pc) begin
        bad++; $display("FAIL %s: PC=%h imem_addr=%h expected %h", e.name, PC, imem_addr, e.pc);
      end
      total++;
      if (IF_ID !== e.if_id) begin
        bad++; $display("FAIL %s: IF_ID=%h expected %h", e.name, IF_ID, e.if_id);
      end
    end
  endtask

  initial begin
    test_reset();
    test_seq();
    test_stall();
    test_jump();
    test_branch_exception();
    test_pc_plus4_boundary();
    test_irq();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage pipeline, directly upstream of the decode stage.
- Owns the PC register and reads the instruction ROM combinationally.
- Arbitrates all PC redirects: EX branch, ID jump/jr, ID illegal-op exception, external interrupt.
- Loads the IF/ID pipeline register consumed by decode; honours decode's load-use stall.

Parameters:
- RESET_PC, 32'h8000_0000, PC after reset (supervisor space).
- ILLOP_PC, 32'h8000_0004, exception vector.
- XADR_PC, 32'h8000_0008, interrupt vector.

Ports:
- clk  in  1  clock
- reset_b  in  1  reset
- bubble  in  1  load-use stall from decode
- PCSrcJ  in  1  j/jal decoded in ID
- PCSrcJR  in  1  jr/jalr decoded in ID
- jump_address  in  32  j/jal target
- jr_address  in  32  jr/jalr target
- exception  in  1  illegal opcode decoded in ID
- EX_BranchTaken  in  1  branch resolved taken in EX
- EX_BranchAddress  in  32  branch target from EX
- IRQ  in  1  external interrupt, level
- imem_addr  out  32  equals PC
- imem_rdata  in  32  instruction at imem_addr, same cycle
- flush_ID  out  1  decode must load zero into ID/EX this edge
- PC  out  32  current PC
- IF_ID  out  65  [31:0] PC_Plus4, [63:32] Instruction, [64] irq marker

Behaviour:
- Reset and clocking:
  - reset_b is asynchronous, active-low; clk is the clock.
  - On reset: PC=RESET_PC, IF_ID=0, irq_pending=0.
  - Reset mid-operation discards all in-flight state immediately.
- PC_Plus4 = {PC[31], PC[30:0]+31'd4}. The supervisor bit is never set by incrementing, and bit-30 carry does not propagate.
- Per-edge priority (first match wins):
  1. EX_BranchTaken: PC<=EX_BranchAddress; IF_ID<=0. Overrides bubble, because the branch instruction is older.
  2. bubble: PC and IF_ID hold. ID-side redirects (exception, PCSrcJR, PCSrcJ) are ignored because the instruction will be re-presented.
  3. exception: PC<=ILLOP_PC; IF_ID<=0.
  4. PCSrcJR: PC<=jr_address; IF_ID<=0.
  5. PCSrcJ: PC<=jump_address; IF_ID<=0.
  6. irq_pending: PC<=XADR_PC; IF_ID<={1'b1, 32'h0, PC_Plus4}. The fetched instruction is dropped; the handler returns to $k0-4.
  7. Otherwise: PC<=PC_Plus4; IF_ID<={1'b0, imem_rdata, PC_Plus4}.
- flush_ID: combinational, equals EX_BranchTaken. Only branches kill the instruction in ID; there are no delay slots.
- irq_pending:
  - Set at an edge where IRQ=1, PC[31]=0 and irq_pending=0.
  - Cleared at the edge where rule 6 fires.
  - Preempted by rules 1-5; it waits and fires at the first free edge.
  - If PC[31] becomes 1 before acceptance (redirect into kernel), it stays pending but is not accepted until PC[31]=0.
  - Never accepted while PC[31]=1.
- Simultaneous events:
  - EX_BranchTaken with exception: the branch wins; the excepting instruction is flushed.
  - PCSrcJ with PCSrcJR both high: treated as JR (not legal from decode).
- Latency: one cycle from redirect input to the new PC on imem_addr. A taken branch costs 2 bubbles; j/jr/exception cost 1.
- IF_ID=0 decodes as sll $0,$0,0 (NOP).

Test Plan:
- Reset, then straight-line fetch:
  - Release reset with ROM[0x80000000]=0x20080005 -> imem_addr=0x80000000.
  - Next edge: IF_ID[63:32]=0x20080005, IF_ID[31:0]=0x80000004, PC=0x80000004.
- Stall:
  - bubble=1 for 2 cycles at PC=0x80000010 -> PC and IF_ID unchanged for both edges; sequential fetch resumes after.
- Jump:
  - PCSrcJ=1, jump_address=0x80000100 -> PC=0x80000100, IF_ID=0.
  - Same with bubble=1 -> PC holds, no redirect.
- Branch over stall:
  - EX_BranchTaken=1, EX_BranchAddress=0x80000040, bubble=1, PCSrcJ=1 -> PC=0x80000040, IF_ID=0, flush_ID=1 in that cycle.
- Exception:
  - exception=1 -> PC=0x80000004, IF_ID=0.
  - exception with EX_BranchTaken -> branch target wins.
- Interrupt:
  - PC=0x00000200, IRQ pulse -> irq_pending set; next free edge PC=0x80000008, IF_ID={1,0,0x00000204}.
  - IRQ held while PC=0x80000008 -> no second acceptance.
  - Mid-stream reset_b=0 -> PC=0x80000000, IF_ID=0 asynchronously.
